uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter: serialises one DATA_BITS word per request into an

---
 rtl/uart_tx_cfg.sv | 144 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB-first,
// optional parity, 1 or 2 stop bits, integer clock divider, one-cycle done pulse.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 cts,
    output logic                 txd,
    output logic                 done
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     baud_reg;
    logic [3:0]           bit_reg;
    logic                 stop_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 txd_reg;
    logic                 cts_reg;
    logic                 done_reg;

    // Parity is fixed at acceptance so later changes on data cannot leak into the frame.
    logic parity_next;
    assign parity_next = (PARITY == 2) ? (^data) : (~^data);

    logic baud_last;
    assign baud_last = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            txd_reg    <= 1'b1;
            cts_reg    <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            baud_reg <= baud_last ? '0 : baud_reg + 1'b1;
            case (state_reg)
                S_IDLE: begin
                    baud_reg <= '0;
                    if (send) begin
                        shift_reg  <= data;
                        parity_reg <= parity_next;
                        txd_reg    <= 1'b0;
                        cts_reg    <= 1'b0;
                        state_reg  <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        bit_reg   <= '0;
                        txd_reg   <= shift_reg[0];
                        state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        if (bit_reg == DATA_LAST) begin
                            stop_reg <= 1'b0;
                            if (PARITY != 0) begin
                                txd_reg   <= parity_reg;
                                state_reg <= S_PARITY;
                            end else begin
                                txd_reg   <= 1'b1;
                                state_reg <= S_STOP;
                            end
                        end else begin
                            bit_reg   <= bit_reg + 1'b1;
                            txd_reg   <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        txd_reg   <= 1'b1;
                        stop_reg  <= 1'b0;
                        state_reg <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        if (stop_reg == STOP_LAST) begin
                            cts_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            stop_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    txd_reg   <= 1'b1;
                    cts_reg   <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cts  = cts_reg;
    assign txd  = txd_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: four parameterisations, table-driven frames plus
// hand-written sequences for back-to-back, ignored requests and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] send_v;
    logic [8:0] data_v [4];
    wire  [3:0] cts_v;
    wire  [3:0] txd_v;
    wire  [3:0] done_v;

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u_def (
        .clk(clk), .rst(rst), .send(send_v[0]), .data(data_v[0][7:0]),
        .cts(cts_v[0]), .txd(txd_v[0]), .done(done_v[0]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .send(send_v[1]), .data(data_v[1][7:0]),
        .cts(cts_v[1]), .txd(txd_v[1]), .done(done_v[1]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .send(send_v[2]), .data(data_v[2][7:0]),
        .cts(cts_v[2]), .txd(txd_v[2]), .done(done_v[2]));
    uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_short (
        .clk(clk), .rst(rst), .send(send_v[3]), .data(data_v[3][6:0]),
        .cts(cts_v[3]), .txd(txd_v[3]), .done(done_v[3]));

    int n_cmp = 0;
    int n_bad = 0;

    // bits[j] is the line level of frame bit j (start, data..., parity); stop bits are implied high.
    typedef struct {
        int          inst;
        logic [8:0]  word;
        logic [11:0] bits;
        int          nbits;
        int          cpb;
        int          flen;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called right after a negedge; returns after the accepting posedge E0.
    task automatic start_frame(input int inst, input logic [8:0] word);
        data_v[inst] = word;
        send_v[inst] = 1'b1;
        @(posedge clk);
    endtask

    // Samples E0+0 .. E0+flen on negedges; returns positioned at the negedge after E0+flen.
    task automatic check_frame(input vec_t v, input bit hold, input logic [8:0] mid_word,
                               input int pulse_at, input string tag);
        logic bit_bad [13];
        logic ctrl_bad;
        logic exp_txd;
        for (int j = 0; j < 13; j++) bit_bad[j] = 1'b0;
        ctrl_bad = 1'b0;
        for (int k = 0; k <= v.flen; k++) begin
            @(negedge clk);
            if (k < v.flen) begin
                exp_txd = (k < v.nbits * v.cpb) ? v.bits[k / v.cpb] : 1'b1;
                if (txd_v[v.inst] !== exp_txd) bit_bad[k / v.cpb] = 1'b1;
                if (cts_v[v.inst] !== 1'b0 || done_v[v.inst] !== 1'b0) ctrl_bad = 1'b1;
            end else begin
                check({tag, " done_at_end"}, {31'b0, done_v[v.inst]}, 32'd1);
                check({tag, " cts_at_end"},  {31'b0, cts_v[v.inst]},  32'd1);
                check({tag, " txd_at_end"},  {31'b0, txd_v[v.inst]},  32'd1);
            end
            if (k == 0 && !hold) send_v[v.inst] = 1'b0;
            if (hold && k == v.flen / 2) data_v[v.inst] = mid_word;
            if (k == pulse_at) send_v[v.inst] = 1'b1;
            if (k == pulse_at + 1) send_v[v.inst] = 1'b0;
        end
        for (int j = 0; j < v.flen / v.cpb; j++)
            check($sformatf("%s bit%0d_wrong", tag, j), {31'b0, bit_bad[j]}, 32'd0);
        check({tag, " cts_or_done_in_frame"}, {31'b0, ctrl_bad}, 32'd0);
        $display("frame inst=%0d data=%0h len=%0d (%s)", v.inst, v.word, v.flen, tag);
    endtask

    task automatic check_idle(input int inst, input int cycles, input string tag);
        logic moved;
        moved = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (txd_v[inst] !== 1'b1 || cts_v[inst] !== 1'b1 || done_v[inst] !== 1'b0) moved = 1'b1;
        end
        check({tag, " idle_activity"}, {31'b0, moved}, 32'd0);
    endtask

    vec_t v;

    initial begin
        vecs[0] = '{0, 9'h0A5, 12'b0001_0100_1010,  9, 16, 160};
        vecs[1] = '{0, 9'h000, 12'b0000_0000_0000,  9, 16, 160};
        vecs[2] = '{0, 9'h0FF, 12'b0001_1111_1110,  9, 16, 160};
        vecs[3] = '{1, 9'h007, 12'b0010_0000_1110, 10, 16, 176};
        vecs[4] = '{2, 9'h007, 12'b0000_0000_1110, 10, 16, 176};
        vecs[5] = '{1, 9'h000, 12'b0000_0000_0000, 10, 16, 176};
        vecs[6] = '{2, 9'h000, 12'b0010_0000_0000, 10, 16, 176};
        vecs[7] = '{3, 9'h055, 12'b0000_1010_1010,  8,  4,  40};
        vecs[8] = '{3, 9'h07F, 12'b0000_1111_1110,  8,  4,  40};

        rst    = 1'b1;
        send_v = 4'b0000;
        for (int i = 0; i < 4; i++) data_v[i] = 9'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset inst%0d txd", i),  {31'b0, txd_v[i]},  32'd1);
            check($sformatf("reset inst%0d cts", i),  {31'b0, cts_v[i]},  32'd1);
            check($sformatf("reset inst%0d done", i), {31'b0, done_v[i]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            start_frame(vecs[i].inst, vecs[i].word);
            check_frame(vecs[i], 1'b0, 9'h0, -10, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", i), {31'b0, done_v[vecs[i].inst]}, 32'd0);
            check($sformatf("vec%0d cts_idle", i),       {31'b0, cts_v[vecs[i].inst]},  32'd1);
        end

        // send held high, data changed mid-frame: second frame starts one idle cycle later
        start_frame(0, 9'h000);
        check_frame(vecs[1], 1'b1, 9'h0FF, -10, "b2b_first");
        start_frame(0, 9'h0FF);
        check_frame(vecs[2], 1'b0, 9'h0, -10, "b2b_second");
        check_idle(0, 40, "b2b_after");

        // request while busy is dropped
        start_frame(0, 9'h0A5);
        check_frame(vecs[0], 1'b0, 9'h0, 30, "busy_send");
        check_idle(0, 200, "busy_send_after");

        // reset in the middle of data bit 3 aborts the frame
        start_frame(0, 9'h0A5);
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            if (k == 0) send_v[0] = 1'b0;
        end
        check("abort txd_mid_bit3", {31'b0, txd_v[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort txd", {31'b0, txd_v[0]},  32'd1);
        check("abort cts", {31'b0, cts_v[0]},  32'd1);
        check("abort done", {31'b0, done_v[0]}, 32'd0);
        rst = 1'b0;
        check_idle(0, 200, "abort_after");
        $display("frame inst=0 data=a5 aborted by reset");
        @(negedge clk);
        start_frame(0, 9'h0A5);
        check_frame(vecs[0], 1'b0, 9'h0, -10, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule
